ddr2idxbuf: RTL
===============

# ddr2idxbuf

Parametrised DDR-to-index-buffer loader: unpacks DDR beats into index pairs and writes them, one per cycle, into the index buffers of a masked set of PEs. It sits between the DDR read-stream arbiter and the per-PE index buffers. It adds a true valid/ready handshake with backpressure, a configurable base address with wrap, partial-last-beat handling, and a done pulse.

## Interface
Parameters:
- DDR_W, 512, DDR beat width.
- IDX_W, 16, width of one index; a buffer entry is IDX_W*2.
- IDX_DEPTH, 256, index buffer depth.
- ADDR_W, bw(IDX_DEPTH), buffer address width.
- PE_NUM, 32, number of PE index buffers.
- IDX_BATCH, DDR_W/(IDX_W*2), entries per beat (derived; DDR_W must be a multiple of IDX_W*2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous and active-low.
- start  in  1  one-cycle pulse that latches the conf_* inputs.
- done  out  1  level; high when idle.
- done_pulse  out  1  one-cycle pulse at job completion.
- conf_mode  in  4  conf_mode[2:1]==2'b01 swaps the two IDX_W halves of each entry.
- conf_idx_num  in  ADDR_W+1  number of entries to write, 0..IDX_DEPTH.
- conf_base  in  ADDR_W  first write address.
- conf_mask  in  PE_NUM  target PE buffers.
- ddr_data  in  DDR_W  beat; entry 0 is in bits [IDX_W*2-1:0].
- ddr_valid  in  1  beat valid.
- ddr_ready  out  1  beat accepted when valid&&ready at a rising edge.
- idx_wr_data  out  IDX_W*2  entry data.
- idx_wr_addr  out  ADDR_W  entry address.
- idx_wr_en  out  PE_NUM  per-PE write enable.

## Operation
- FSM states: IDLE, LOAD.
- IDLE
  - done=1, ddr_ready=0.
  - On start with conf_idx_num>0: latch the conf_* inputs, clear idx_cnt, go to LOAD.
  - On start with conf_idx_num==0: stay in IDLE and assert done_pulse for one cycle; no DDR traffic.
- LOAD
  - Holds one beat register, a full flag and a slot counter (0..IDX_BATCH-1).
  - ddr_ready = !full || last_slot_emitting. It is derived from registers only, never from ddr_valid.
  - On handshake: capture the beat, set full, reset slot to 0.
  - While full, each cycle emits one entry:
    - data = beat[slot], half-swapped if the mode selects it;
    - addr = conf_base + idx_cnt, truncated to ADDR_W (wraps modulo IDX_DEPTH);
    - en = latched mask.
    - Then idx_cnt and slot increment.
  - The beat empties when slot==IDX_BATCH-1 or idx_cnt==conf_idx_num-1.
  - Slots left in a partial last beat are discarded.
  - After the entry with idx_cnt==conf_idx_num-1: clear ddr_ready, return to IDLE, pulse done_pulse.
- start while in LOAD is ignored.
- conf_* inputs changing after start have no effect.
- ddr_valid while in IDLE is not accepted; the beat stays pending upstream.
- A mask of zero still runs the full sequence, with idx_wr_en all-zero.

## Timing
- Reset values:
  - state=IDLE, done=1, done_pulse=0, ddr_ready=0;
  - idx_wr_en=0, idx_wr_data=0, idx_wr_addr=0;
  - full=0, idx_cnt=0.
- Asserting rst_n low mid-job aborts immediately. Any partially loaded beat is dropped and no further writes occur.
- start at edge S: done low and ddr_ready high from cycle S+1.
- Write outputs are registered. A beat accepted at edge E0 gives entry 0 on the write port from edge E0+1 for one cycle; entry k appears at E0+1+k.
- Sustained throughput is 1 entry per cycle. The next beat is accepted at the edge that emits the last slot, so there is no bubble between beats when ddr_valid is held high.
- Backpressure from ddr_valid low: idx_wr_en=0 in the gap cycles; counters hold.
- The final write is presented at edge F. done_pulse is high and done rises at edge F+1.

## Structure
- The shared package GLOBAL_PARAM provides:
  - DDR_W, IDX_W, bw();
  - a state enum typedef ddr2idx_state_t {IDLE, LOAD}.
- One natural sub-module: idx_unpack (beat register, full flag, slot counter, half swap), reusable by the weight/bias loaders.
- Top-level logic: FSM, address/count generation, write-port registers.

## Test plan
- IDX_BATCH=16, idx_num=40, base=0, mask=32'h0000_000F, ddr_valid held high:
  - 3 beats accepted; 40 contiguous writes to addr 0..39 on PEs 0-3;
  - entries 8-15 of beat 2 discarded;
  - done_pulse at edge F+1.
- Mode 4'b0010 with entry 32'hAAAA_5555 → written data 32'h5555_AAAA.
- base=250, idx_num=10 → addresses 250..255 then 0..3.
- ddr_valid toggled 1/0 every cycle with idx_num=32:
  - writes only in cycles with a full beat register;
  - no beat lost or duplicated;
  - addresses strictly sequential.
- start with idx_num=0 → done stays high, one done_pulse, ddr_ready never asserts. start re-pulsed mid-LOAD → no effect on count or addresses.
- rst_n asserted low after the 5th write of a 20-entry job → all outputs at reset values immediately. A new job then completes correctly from base.

Source files
------------

// File: rtl/ddr2idxbuf_pkg.sv
// Shared constants, width helper and FSM state type for the DDR index loader
// and its beat-unpacking helper.
package ddr2idxbuf_pkg;

  localparam int DDR_W = 512;
  localparam int IDX_W = 16;

  // Address width needed for n locations; never narrower than one bit.
  function automatic int bw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    IDLE,
    LOAD
  } ddr2idx_state_t;

endpackage

// File: rtl/ddr2idxbuf_idx_unpack.sv
// Holds one DDR beat and hands out its entries one slot at a time, optionally
// swapping the two halves of each entry.
module idx_unpack
  import ddr2idxbuf_pkg::*;
#(
  parameter int BEAT_W = 512,
  parameter int ENT_W  = 32,
  parameter int BATCH  = BEAT_W / ENT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              load,
  input  logic [BEAT_W-1:0] beat_in,
  input  logic              pop,
  input  logic              pop_last,
  input  logic              swap,
  output logic              full,
  output logic              last_slot,
  output logic [ENT_W-1:0]  entry
);

  localparam int SLOT_W = bw(BATCH);
  localparam int HALF_W = ENT_W / 2;

  logic [BATCH-1:0][ENT_W-1:0] beat_q, beat_d;
  logic                        full_q, full_d;
  logic [SLOT_W-1:0]           slot_q, slot_d;
  logic [ENT_W-1:0]            raw;

  // A load in the same cycle as the final pop refills the register without a bubble.
  always_comb begin
    beat_d = beat_q;
    full_d = full_q;
    slot_d = slot_q;
    if (pop) begin
      slot_d = slot_q + SLOT_W'(1);
      if (pop_last) full_d = 1'b0;
    end
    if (load) begin
      beat_d = beat_in;
      full_d = 1'b1;
      slot_d = '0;
    end
    if (flush) begin
      full_d = 1'b0;
      slot_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= '0;
      full_q <= 1'b0;
      slot_q <= '0;
    end else begin
      beat_q <= beat_d;
      full_q <= full_d;
      slot_q <= slot_d;
    end
  end

  assign raw       = beat_q[slot_q];
  assign entry     = swap ? {raw[HALF_W-1:0], raw[ENT_W-1:HALF_W]} : raw;
  assign full      = full_q;
  assign last_slot = (slot_q == SLOT_W'(BATCH - 1));

endmodule

// File: rtl/ddr2idxbuf.sv
// Loads index pairs from a DDR beat stream into the index buffers of a masked
// set of PEs, one entry per cycle, starting at a wrapping base address.
module ddr2idxbuf
  import ddr2idxbuf_pkg::*;
#(
  parameter int DDR_W     = ddr2idxbuf_pkg::DDR_W,
  parameter int IDX_W     = ddr2idxbuf_pkg::IDX_W,
  parameter int IDX_DEPTH = 256,
  parameter int ADDR_W    = bw(IDX_DEPTH),
  parameter int PE_NUM    = 32,
  parameter int IDX_BATCH = DDR_W / (IDX_W * 2)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 done,
  output logic                 done_pulse,
  input  logic [3:0]           conf_mode,
  input  logic [ADDR_W:0]      conf_idx_num,
  input  logic [ADDR_W-1:0]    conf_base,
  input  logic [PE_NUM-1:0]    conf_mask,
  input  logic [DDR_W-1:0]     ddr_data,
  input  logic                 ddr_valid,
  output logic                 ddr_ready,
  output logic [IDX_W*2-1:0]   idx_wr_data,
  output logic [ADDR_W-1:0]    idx_wr_addr,
  output logic [PE_NUM-1:0]    idx_wr_en
);

  localparam int ENT_W = IDX_W * 2;

  ddr2idx_state_t     state_q, state_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic [ADDR_W:0]    num_q, num_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [PE_NUM-1:0]  mask_q, mask_d;
  logic               swap_q, swap_d;
  logic [ENT_W-1:0]   wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [PE_NUM-1:0]  wr_en_q, wr_en_d;
  logic               done_q, done_d;
  logic               done_pulse_q, done_pulse_d;
  logic               fin_q, fin_d;
  logic               start_job;

  logic               in_load, full, last_slot, emit, job_last, ready, load;
  logic [ENT_W-1:0]   entry;
  logic               unused_mode;

  assign unused_mode = ^{conf_mode[3], conf_mode[0]};

  assign in_load  = (state_q == LOAD);
  assign emit     = in_load && full;
  assign job_last = (cnt_q == num_q - (ADDR_W + 1)'(1));
  // The job's final entry must not pull in another beat that would be lost.
  assign ready    = in_load && (!full || (last_slot && !job_last));
  assign load     = ready && ddr_valid;

  idx_unpack #(
    .BEAT_W (DDR_W),
    .ENT_W  (ENT_W),
    .BATCH  (IDX_BATCH)
  ) u_unpack (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (start_job),
    .load      (load),
    .beat_in   (ddr_data),
    .pop       (emit),
    .pop_last  (job_last || last_slot),
    .swap      (swap_q),
    .full      (full),
    .last_slot (last_slot),
    .entry     (entry)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    num_d        = num_q;
    base_d       = base_q;
    mask_d       = mask_q;
    swap_d       = swap_q;
    wr_data_d    = wr_data_q;
    wr_addr_d    = wr_addr_q;
    wr_en_d      = '0;
    done_d       = done_q;
    done_pulse_d = 1'b0;
    fin_d        = 1'b0;
    start_job    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !fin_q) begin
          if (conf_idx_num != '0) begin
            num_d     = conf_idx_num;
            base_d    = conf_base;
            mask_d    = conf_mask;
            swap_d    = (conf_mode[2:1] == 2'b01);
            cnt_d     = '0;
            done_d    = 1'b0;
            start_job = 1'b1;
            state_d   = LOAD;
          end else begin
            done_pulse_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (emit) begin
          wr_data_d = entry;
          wr_addr_d = base_q + cnt_q[ADDR_W-1:0];
          wr_en_d   = mask_q;
          cnt_d     = cnt_q + (ADDR_W + 1)'(1);
          if (job_last) begin
            state_d = IDLE;
            fin_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Completion is reported one cycle after the final write is on the port.
    if (fin_q) begin
      done_d       = 1'b1;
      done_pulse_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      num_q        <= '0;
      base_q       <= '0;
      mask_q       <= '0;
      swap_q       <= 1'b0;
      wr_data_q    <= '0;
      wr_addr_q    <= '0;
      wr_en_q      <= '0;
      done_q       <= 1'b1;
      done_pulse_q <= 1'b0;
      fin_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      num_q        <= num_d;
      base_q       <= base_d;
      mask_q       <= mask_d;
      swap_q       <= swap_d;
      wr_data_q    <= wr_data_d;
      wr_addr_q    <= wr_addr_d;
      wr_en_q      <= wr_en_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      fin_q        <= fin_d;
    end
  end

  assign ddr_ready   = ready;
  assign done        = done_q;
  assign done_pulse  = done_pulse_q;
  assign idx_wr_data = wr_data_q;
  assign idx_wr_addr = wr_addr_q;
  assign idx_wr_en   = wr_en_q;

endmodule
